// File: rtl/bp_score_unit.sv
// Trace sequencer and scorer for the perceptron predictor: presents each record,
// waits PRED_LAT cycles, scores the prediction and keeps saturating totals.
module bp_score_unit #(
  parameter int unsigned ADDR_WID = 32,
  parameter int unsigned PRED_LAT = 1,
  parameter int unsigned CNT_WID  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_WID-1:0] in_addr,
  input  logic                in_taken,
  input  logic                clr,
  output logic [ADDR_WID-1:0] bp_addr,
  output logic                bp_taken,
  input  logic                bp_prediction,
  output logic                out_valid,
  output logic                out_mispredict,
  output logic [CNT_WID-1:0]  branch_count,
  output logic [CNT_WID-1:0]  mispredict_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SCORE = 2'd2;

  // Last wait_cnt value spent in WAIT; unused when PRED_LAT is 0.
  localparam logic [3:0] LAT_LAST = (PRED_LAT > 0) ? 4'(PRED_LAT - 1) : 4'd0;
  localparam logic [1:0] S_AFTER_ACCEPT = (PRED_LAT > 0) ? S_WAIT : S_SCORE;

  logic [1:0]          state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDR_WID-1:0] addr_q, addr_d;
  logic                taken_q, taken_d;
  logic                ovalid_q, ovalid_d;
  logic                omis_q, omis_d;
  logic [CNT_WID-1:0]  bcnt_q, bcnt_d;
  logic [CNT_WID-1:0]  mcnt_q, mcnt_d;
  logic                mis;

  assign mis = bp_prediction ^ taken_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    taken_d    = taken_q;
    ovalid_d   = 1'b0;
    omis_d     = omis_q;
    bcnt_d     = bcnt_q;
    mcnt_d     = mcnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d     = in_addr;
          taken_d    = in_taken;
          wait_cnt_d = '0;
          state_d    = S_AFTER_ACCEPT;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (wait_cnt_q == LAT_LAST) state_d = S_SCORE;
      end
      S_SCORE: begin
        ovalid_d = 1'b1;
        omis_d   = mis;
        if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_WID'(1);
        if (mis && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_WID'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear overrides a coincident score update; the per-record result still goes out.
    if (clr) begin
      bcnt_d = '0;
      mcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      taken_q    <= 1'b0;
      ovalid_q   <= 1'b0;
      omis_q     <= 1'b0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      taken_q    <= taken_d;
      ovalid_q   <= ovalid_d;
      omis_q     <= omis_d;
      bcnt_q     <= bcnt_d;
      mcnt_q     <= mcnt_d;
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign bp_addr          = addr_q;
  assign bp_taken         = taken_q;
  assign out_valid        = ovalid_q;
  assign out_mispredict   = omis_q;
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_bp_score_unit.sv
// Directed bench for bp_score_unit: three builds (PRED_LAT=1, PRED_LAT=0, CNT_WID=4).
module tb_bp_score_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, clr = 1'b0, pred = 1'b0;

  // Build A: PRED_LAT=1, 32-bit counters
  logic        va = 1'b0, ta = 1'b0, ra, bta, ova, oma;
  logic [31:0] aa = '0, bpa, bca, mca;
  // Build B: PRED_LAT=0
  logic        vb = 1'b0, tb = 1'b0, rb, btb, ovb, omb;
  logic [31:0] ab = '0, bpb, bcb, mcb;
  // Build C: PRED_LAT=1, 4-bit counters
  logic        vc = 1'b0, tc = 1'b0, rc, btc, ovc, omc;
  logic [31:0] ac = '0, bpc;
  logic [3:0]  bcc, mcc;

  int tests = 0;
  int fails = 0;

  bp_score_unit #(.ADDR_WID(32), .PRED_LAT(1), .CNT_WID(32)) u_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_addr(aa), .in_taken(ta),
    .clr(clr), .bp_addr(bpa), .bp_taken(bta), .bp_prediction(pred),
    .out_valid(ova), .out_mispredict(oma), .branch_count(bca), .mispredict_count(mca));

  bp_score_unit #(.ADDR_WID(32), .PRED_LAT(0), .CNT_WID(32)) u_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_addr(ab), .in_taken(tb),
    .clr(clr), .bp_addr(bpb), .bp_taken(btb), .bp_prediction(pred),
    .out_valid(ovb), .out_mispredict(omb), .branch_count(bcb), .mispredict_count(mcb));

  bp_score_unit #(.ADDR_WID(32), .PRED_LAT(1), .CNT_WID(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(vc), .in_ready(rc), .in_addr(ac), .in_taken(tc),
    .clr(clr), .bp_addr(bpc), .bp_taken(btc), .bp_prediction(pred),
    .out_valid(ovc), .out_mispredict(omc), .branch_count(bcc), .mispredict_count(mcc));

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; va = 1'b1; aa = 32'hDEAD_BEEF; ta = 1'b1;
    vb = 1'b1; ab = 32'h1234_5678; tb = 1'b1;
    tick();
    tick();
    tests++; if (ra !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", ra); end
    tests++; if (bpa !== 32'h0) begin fails++; $display("FAIL reset_bp_addr got=%h exp=0", bpa); end
    tests++; if ({bta, ova, oma} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {bta, ova, oma}); end
    tests++; if ({bca, mca} !== 64'h0) begin fails++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bca, mca); end
    tests++; if (bpb !== 32'h0) begin fails++; $display("FAIL reset_bp_addr_b got=%h exp=0", bpb); end
    va = 1'b0; vb = 1'b0; rst = 1'b0;
    tick();
    tests++; if (bpa !== 32'h0 || ra !== 1'b1) begin fails++; $display("FAIL reset_no_accept got=%h/%b exp=0/1", bpa, ra); end
  endtask

  task automatic test_single();
    do_reset();
    pred = 1'b0; va = 1'b1; aa = 32'h0000_1040; ta = 1'b1;
    tests++; if (ra !== 1'b1) begin fails++; $display("FAIL single_ready_c0 got=%b exp=1", ra); end
    tick();  // C0+1
    va = 1'b0; aa = 32'hFFFF_FFFF; ta = 1'b0;
    tests++; if (bpa !== 32'h0000_1040 || bta !== 1'b1) begin fails++; $display("FAIL single_bp got=%h/%b exp=00001040/1", bpa, bta); end
    tests++; if (ra !== 1'b0 || ova !== 1'b0) begin fails++; $display("FAIL single_c1 ready/valid got=%b/%b exp=0/0", ra, ova); end
    tick();  // C0+2 (SCORE)
    tests++; if (ova !== 1'b0 || bpa !== 32'h0000_1040) begin fails++; $display("FAIL single_c2 got=%b/%h exp=0/00001040", ova, bpa); end
    tick();  // C0+3
    tests++; if (ova !== 1'b1 || oma !== 1'b1) begin fails++; $display("FAIL single_result got=%b/%b exp=1/1", ova, oma); end
    tests++; if (bca !== 32'd1 || mca !== 32'd1) begin fails++; $display("FAIL single_counts got=%0d/%0d exp=1/1", bca, mca); end
    tests++; if (ra !== 1'b1) begin fails++; $display("FAIL single_ready_c3 got=%b exp=1", ra); end
    tick();  // C0+4
    tests++; if (ova !== 1'b0 || oma !== 1'b1) begin fails++; $display("FAIL single_hold got=%b/%b exp=0/1", ova, oma); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    logic       prev_mis;
    pat = 8'b1011_0010;
    prev_mis = 1'b0;
    do_reset();
    pred = 1'b1; va = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ta = pat[7-i];
      aa = 32'h100 + 32'(i) * 4;
      tests++; if (ra !== 1'b1) begin fails++; $display("FAIL b2b_ready rec=%0d got=%b exp=1", i, ra); end
      if (i > 0) begin
        tests++; if (ova !== 1'b1 || oma !== prev_mis) begin fails++; $display("FAIL b2b_result rec=%0d got=%b/%b exp=1/%b", i-1, ova, oma, prev_mis); end
      end
      prev_mis = ~pat[7-i];
      tick();
      tests++; if (ova !== 1'b0 || bpa !== 32'h100 + 32'(i) * 4) begin fails++; $display("FAIL b2b_c1 rec=%0d got=%b/%h", i, ova, bpa); end
      tick();
      tests++; if (ova !== 1'b0 || ra !== 1'b0) begin fails++; $display("FAIL b2b_c2 rec=%0d got=%b/%b exp=0/0", i, ova, ra); end
      tick();
    end
    va = 1'b0;
    tests++; if (ova !== 1'b1 || oma !== 1'b1) begin fails++; $display("FAIL b2b_last got=%b/%b exp=1/1", ova, oma); end
    tests++; if (bca !== 32'd8 || mca !== 32'd4) begin fails++; $display("FAIL b2b_counts got=%0d/%0d exp=8/4", bca, mca); end
  endtask

  task automatic test_lat0();
    logic [2:0] pat;
    logic       prev_mis;
    pat = 3'b101;
    prev_mis = 1'b0;
    do_reset();
    pred = 1'b0; vb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tb = pat[2-i];
      ab = 32'hA000 + 32'(i);
      tests++; if (rb !== 1'b1) begin fails++; $display("FAIL lat0_ready rec=%0d got=%b exp=1", i, rb); end
      if (i > 0) begin
        tests++; if (ovb !== 1'b1 || omb !== prev_mis) begin fails++; $display("FAIL lat0_result rec=%0d got=%b/%b exp=1/%b", i-1, ovb, omb, prev_mis); end
      end
      prev_mis = pat[2-i];
      tick();
      tests++; if (ovb !== 1'b0 || rb !== 1'b0 || bpb !== 32'hA000 + 32'(i)) begin fails++; $display("FAIL lat0_score rec=%0d got=%b/%b/%h", i, ovb, rb, bpb); end
      tick();
    end
    vb = 1'b0;
    tests++; if (ovb !== 1'b1 || omb !== 1'b1) begin fails++; $display("FAIL lat0_last got=%b/%b exp=1/1", ovb, omb); end
    tests++; if (bcb !== 32'd3 || mcb !== 32'd2) begin fails++; $display("FAIL lat0_counts got=%0d/%0d exp=3/2", bcb, mcb); end
  endtask

  task automatic test_saturation();
    do_reset();
    pred = 1'b0; vc = 1'b1; tc = 1'b1; ac = 32'h2000;
    for (int i = 0; i < 20; i++) begin
      tick();
      tick();
      tick();
      if (i == 14) begin
        tests++; if (bcc !== 4'd15 || mcc !== 4'd15) begin fails++; $display("FAIL sat_at15 got=%0d/%0d exp=15/15", bcc, mcc); end
      end
    end
    vc = 1'b0;
    tests++; if (ovc !== 1'b1 || bcc !== 4'd15 || mcc !== 4'd15) begin fails++; $display("FAIL sat_stick got=%b/%0d/%0d exp=1/15/15", ovc, bcc, mcc); end
  endtask

  task automatic test_clr_in_score();
    tests++; if (bcc !== 4'd15) begin fails++; $display("FAIL clr_pre got=%0d exp=15", bcc); end
    pred = 1'b0; vc = 1'b1; tc = 1'b1; ac = 32'h3000;
    tick();  // WAIT
    vc = 1'b0;
    tick();  // SCORE
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++; if (ovc !== 1'b1 || omc !== 1'b1) begin fails++; $display("FAIL clr_pulse got=%b/%b exp=1/1", ovc, omc); end
    tests++; if (bcc !== 4'd0 || mcc !== 4'd0) begin fails++; $display("FAIL clr_counts got=%0d/%0d exp=0/0", bcc, mcc); end
    tests++; if (bpc !== 32'h3000 || btc !== 1'b1) begin fails++; $display("FAIL clr_bp got=%h/%b exp=00003000/1", bpc, btc); end
  endtask

  task automatic test_rst_mid_record();
    int pulses;
    do_reset();
    pred = 1'b1; va = 1'b1; aa = 32'h5000; ta = 1'b0;
    tick();  // WAIT
    va = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (ra !== 1'b1 || bpa !== 32'h0 || ova !== 1'b0) begin fails++; $display("FAIL rstmid_state got=%b/%h/%b exp=1/0/0", ra, bpa, ova); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (ova === 1'b1) pulses++;
      tick();
    end
    tests++; if (pulses !== 0 || bca !== 32'd0 || mca !== 32'd0) begin fails++; $display("FAIL rstmid_drop got=%0d/%0d/%0d exp=0/0/0", pulses, bca, mca); end
    va = 1'b1; aa = 32'h6000; ta = 1'b1;
    tick();
    va = 1'b0;
    tick();
    tick();
    tests++; if (ova !== 1'b1 || oma !== 1'b0 || bca !== 32'd1 || mca !== 32'd0) begin fails++; $display("FAIL rstmid_next got=%b/%b/%0d/%0d exp=1/0/1/0", ova, oma, bca, mca); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lat0();
    test_saturation();
    test_clr_in_score();
    test_rst_mid_record();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_score_unit.md
# bp_score_unit

Upstream sequencer and scorer for the perceptron branch-predictor top. Accepts branch trace records (address, resolved direction) over a valid/ready handshake and presents each to the predictor's b_addr/b_taken inputs. It waits a fixed predictor latency, samples the prediction, and flags a mispredict per record. It also keeps saturating totals of branches scored and mispredictions for the testbench and accuracy reporting.

## Interface
- ADDR_WID, 32, branch address width; matches the predictor's address width
- PRED_LAT, 1, cycles from b_addr first stable to prediction valid; range 0..15
- CNT_WID, 32, width of the statistics counters

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  trace record offered
- in_ready  out  1  block can accept a record
- in_addr  in  ADDR_WID  branch address
- in_taken  in  1  resolved branch direction
- clr  in  1  synchronous clear of statistics counters
- bp_addr  out  ADDR_WID  to predictor b_addr
- bp_taken  out  1  to predictor b_taken
- bp_prediction  in  1  from predictor prediction
- out_valid  out  1  one-cycle pulse: per-record result valid
- out_mispredict  out  1  result: prediction != taken, valid with out_valid
- branch_count  out  CNT_WID  records scored since reset/clr
- mispredict_count  out  CNT_WID  mispredictions since reset/clr

## Operation
- One clock, synchronous active-high reset. On rst all registers clear:
  - state=IDLE, in_ready=1, bp_addr=0, bp_taken=0
  - out_valid=0, out_mispredict=0, both counters 0
- FSM states: IDLE, WAIT, SCORE.
- IDLE: in_ready=1.
  - On in_valid&in_ready the block latches in_addr into bp_addr and in_taken into bp_taken, and loads wait_cnt=0.
  - Next state is WAIT if PRED_LAT>0, else SCORE.
- WAIT: in_ready=0. wait_cnt increments each cycle. Transition to SCORE on the cycle wait_cnt==PRED_LAT-1.
- SCORE: in_ready=0.
  - Sample bp_prediction and compute mis = bp_prediction ^ bp_taken.
  - At the closing edge: register out_valid=1 and out_mispredict=mis.
  - branch_count += 1 (saturating); mispredict_count += mis (saturating).
  - Next state IDLE.
- bp_addr/bp_taken hold their values from the accept edge until the next accept. They never change in WAIT or SCORE.
- out_mispredict holds its last value while out_valid=0.
- Saturation: each counter stops at 2^CNT_WID-1 independently. No wrap.
- clr: counters go to 0 at the edge.
  - If clr coincides with a SCORE update, clr wins: counters become 0, not 1.
  - out_valid/out_mispredict for that record are still produced.
  - clr does not affect the FSM or bp_* outputs.
- rst mid-record (WAIT or SCORE): the record is dropped, with no out_valid pulse. The next cycle is IDLE with all outputs at reset values.
- in_valid while in_ready=0 is ignored; the source must hold the record until accepted.

## Timing
- Accept at edge E0 (cycle C0 has in_valid&in_ready).
  - bp_addr is valid from C0+1.
  - SCORE occupies cycle C0+1+PRED_LAT.
  - out_valid is high during cycle C0+2+PRED_LAT, with counters updated in the same cycle.
- The out_valid cycle is IDLE, so in_ready=1 in that cycle. A back-to-back record can be accepted there.
- Throughput: one record per PRED_LAT+2 cycles.
- PRED_LAT=0: WAIT is skipped and prediction is sampled in C0+1.
- out_valid is never high for two consecutive cycles.

## Test plan
- Reset: drive rst for 2 cycles with in_valid=1 -> in_ready=1, all outputs 0, no acceptance during rst.
- Single record, PRED_LAT=1: accept addr=0x0000_1040, taken=1 at C0; model returns prediction 0 -> bp_addr=0x1040 from C0+1, out_valid=1 and out_mispredict=1 at C0+3, branch_count=1, mispredict_count=1.
- Back-to-back stream, in_valid held high: 8 records with taken pattern 10110010 against a model predicting the constant 1 -> one out_valid every 3 cycles; final branch_count=8, mispredict_count=4.
- PRED_LAT=0 build: 3 records -> out_valid 2 cycles after each accept, accepts every 2 cycles.
- Boundaries, CNT_WID=4:
  - 20 mispredicted records -> both counters stick at 15.
  - clr asserted in a SCORE cycle -> counters read 0 next cycle, out_valid still pulses.
- rst asserted during WAIT -> no out_valid; counters 0. The next record is scored normally with branch_count=1.
